// File: rtl/mips_pkg.sv
// mips_pkg: opcode/funct encodings, reset vector and ALU operation type for the MIPS core
package mips_pkg;
  localparam logic [31:0] RESET_VECTOR = 32'hBFC0_0000;
  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_J       = 6'h02;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_BNE     = 6'h05;
  localparam logic [5:0] OP_ADDIU   = 6'h09;
  localparam logic [5:0] OP_SLTI    = 6'h0A;
  localparam logic [5:0] OP_SLTIU   = 6'h0B;
  localparam logic [5:0] OP_ANDI    = 6'h0C;
  localparam logic [5:0] OP_ORI     = 6'h0D;
  localparam logic [5:0] OP_XORI    = 6'h0E;
  localparam logic [5:0] OP_LUI     = 6'h0F;
  localparam logic [5:0] OP_LW      = 6'h23;
  localparam logic [5:0] OP_SW      = 6'h2B;
  localparam logic [5:0] F_SLL  = 6'h00;
  localparam logic [5:0] F_SRL  = 6'h02;
  localparam logic [5:0] F_SRA  = 6'h03;
  localparam logic [5:0] F_JR   = 6'h08;
  localparam logic [5:0] F_JALR = 6'h09;
  localparam logic [5:0] F_ADDU = 6'h21;
  localparam logic [5:0] F_SUBU = 6'h23;
  localparam logic [5:0] F_AND  = 6'h24;
  localparam logic [5:0] F_OR   = 6'h25;
  localparam logic [5:0] F_XOR  = 6'h26;
  localparam logic [5:0] F_SLT  = 6'h2A;
  localparam logic [5:0] F_SLTU = 6'h2B;
  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLT,
    ALU_SLTU, ALU_SLL, ALU_SRL, ALU_SRA, ALU_LUI
  } alu_op_t;
endpackage

// File: rtl/mips_regfile.sv
// mips_regfile: 32x32 register file, two async reads, one sync write, $0 fixed at zero
module mips_regfile (
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata,
  input  logic [4:0]  raddr_a,
  input  logic [4:0]  raddr_b,
  output logic [31:0] rdata_a,
  output logic [31:0] rdata_b,
  output logic [31:0] v0
);
  logic [31:0] regs [32];
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (we && waddr != 5'd0) begin
      regs[waddr] <= wdata;
    end
  end
  assign rdata_a = raddr_a == 5'd0 ? '0 : regs[raddr_a];
  assign rdata_b = raddr_b == 5'd0 ? '0 : regs[raddr_b];
  assign v0 = regs[2];
endmodule

// File: rtl/mips_harvard_cpu.sv
// mips_harvard_cpu: single-cycle MIPS32 subset core with separate instruction and data ports
module mips_harvard_cpu #(
  parameter logic [31:0] RESET_VECTOR = mips_pkg::RESET_VECTOR
) (
  input  logic        clk,
  input  logic        reset,
  output logic        active,
  output logic [31:0] register_v0,
  input  logic        clk_enable,
  output logic [31:0] instr_address,
  input  logic [31:0] instr_readdata,
  output logic [31:0] data_address,
  output logic        data_write,
  output logic        data_read,
  output logic [31:0] data_writedata,
  input  logic [31:0] data_readdata
);
  import mips_pkg::*;
  logic [31:0] pc, next_pc;
  logic [5:0] opcode, funct;
  logic [4:0] rs, rt, rd, shamt, dest;
  logic [15:0] imm;
  logic [31:0] rs_val, rt_val, sext_imm, zext_imm, op_b, alu_res, wb_data, target;
  logic [31:0] branch_target, jump_target;
  logic use_imm, zero_ext, reg_write, is_load, is_store, link, taken, commit;
  alu_op_t alu_op;
  assign opcode = instr_readdata[31:26];
  assign rs = instr_readdata[25:21];
  assign rt = instr_readdata[20:16];
  assign rd = instr_readdata[15:11];
  assign shamt = instr_readdata[10:6];
  assign funct = instr_readdata[5:0];
  assign imm = instr_readdata[15:0];
  assign sext_imm = {{16{imm[15]}}, imm};
  assign zext_imm = {16'h0, imm};
  assign branch_target = next_pc + {sext_imm[29:0], 2'b00};
  assign jump_target = {next_pc[31:28], instr_readdata[25:0], 2'b00};
  assign commit = reset && active && clk_enable && pc != 32'h0;
  always_comb begin
    alu_op = ALU_ADD;
    use_imm = 1'b0;
    zero_ext = 1'b0;
    reg_write = 1'b0;
    dest = rd;
    is_load = 1'b0;
    is_store = 1'b0;
    link = 1'b0;
    taken = 1'b0;
    target = branch_target;
    case (opcode)
      OP_SPECIAL: begin
        reg_write = 1'b1;
        case (funct)
          F_ADDU: alu_op = ALU_ADD;
          F_SUBU: alu_op = ALU_SUB;
          F_AND:  alu_op = ALU_AND;
          F_OR:   alu_op = ALU_OR;
          F_XOR:  alu_op = ALU_XOR;
          F_SLT:  alu_op = ALU_SLT;
          F_SLTU: alu_op = ALU_SLTU;
          F_SLL:  alu_op = ALU_SLL;
          F_SRL:  alu_op = ALU_SRL;
          F_SRA:  alu_op = ALU_SRA;
          F_JR: begin
            reg_write = 1'b0;
            taken = 1'b1;
            target = rs_val;
          end
          F_JALR: begin
            taken = 1'b1;
            target = rs_val;
            link = 1'b1;
          end
          default: reg_write = 1'b0;
        endcase
      end
      OP_J: begin
        taken = 1'b1;
        target = jump_target;
      end
      OP_JAL: begin
        taken = 1'b1;
        target = jump_target;
        link = 1'b1;
        reg_write = 1'b1;
        dest = 5'd31;
      end
      OP_BEQ: taken = rs_val == rt_val;
      OP_BNE: taken = rs_val != rt_val;
      OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI, OP_LUI, OP_LW: begin
        use_imm = 1'b1;
        reg_write = 1'b1;
        dest = rt;
        zero_ext = opcode == OP_ANDI || opcode == OP_ORI || opcode == OP_XORI;
        is_load = opcode == OP_LW;
        alu_op = opcode == OP_SLTI ? ALU_SLT :
                 opcode == OP_SLTIU ? ALU_SLTU :
                 opcode == OP_ANDI ? ALU_AND :
                 opcode == OP_ORI ? ALU_OR :
                 opcode == OP_XORI ? ALU_XOR :
                 opcode == OP_LUI ? ALU_LUI : ALU_ADD;
      end
      OP_SW: begin
        use_imm = 1'b1;
        is_store = 1'b1;
      end
      default: ;
    endcase
  end
  assign op_b = use_imm ? (zero_ext ? zext_imm : sext_imm) : rt_val;
  always_comb begin
    case (alu_op)
      ALU_ADD:  alu_res = rs_val + op_b;
      ALU_SUB:  alu_res = rs_val - op_b;
      ALU_AND:  alu_res = rs_val & op_b;
      ALU_OR:   alu_res = rs_val | op_b;
      ALU_XOR:  alu_res = rs_val ^ op_b;
      ALU_SLT:  alu_res = {31'h0, $signed(rs_val) < $signed(op_b)};
      ALU_SLTU: alu_res = {31'h0, rs_val < op_b};
      ALU_SLL:  alu_res = rt_val << shamt;
      ALU_SRL:  alu_res = rt_val >> shamt;
      ALU_SRA:  alu_res = $signed(rt_val) >>> shamt;
      ALU_LUI:  alu_res = {imm, 16'h0};
      default:  alu_res = '0;
    endcase
  end
  assign wb_data = is_load ? data_readdata : link ? pc + 32'd8 : alu_res;
  mips_regfile u_regfile (
    .clk(clk),
    .reset(reset),
    .we(commit && reg_write),
    .waddr(dest),
    .wdata(wb_data),
    .raddr_a(rs),
    .raddr_b(rt),
    .rdata_a(rs_val),
    .rdata_b(rt_val),
    .v0(register_v0)
  );
  always_ff @(posedge clk) begin
    if (!reset) begin
      pc <= RESET_VECTOR;
      next_pc <= RESET_VECTOR + 32'd4;
      active <= 1'b1;
    end else if (clk_enable && active) begin
      if (pc == 32'h0) begin
        active <= 1'b0;
      end else begin
        pc <= next_pc;
        next_pc <= taken ? target : next_pc + 32'd4;
      end
    end
  end
  assign instr_address = pc;
  assign data_address = alu_res;
  assign data_writedata = rt_val;
  assign data_write = commit && is_store;
  assign data_read = commit && is_load;
endmodule

// File: tb/tb_mips_harvard_cpu.sv
// tb_mips_harvard_cpu: directed program tests for the single-cycle MIPS core
module tb_mips_harvard_cpu;
  localparam logic [31:0] RV = 32'hBFC0_0000;
  localparam logic [31:0] NOP = 32'h0000_0000;
  localparam logic [31:0] JR0 = 32'h0000_0008;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic clk_enable = 1'b1;
  logic active, data_write, data_read;
  logic [31:0] register_v0, instr_address, instr_readdata;
  logic [31:0] data_address, data_writedata, data_readdata;
  logic [31:0] prog [64];
  logic [31:0] dmem [64] = '{default: 32'h0};
  int passed = 0;
  int total = 0;
  mips_harvard_cpu dut (
    .clk(clk),
    .reset(reset),
    .active(active),
    .register_v0(register_v0),
    .clk_enable(clk_enable),
    .instr_address(instr_address),
    .instr_readdata(instr_readdata),
    .data_address(data_address),
    .data_write(data_write),
    .data_read(data_read),
    .data_writedata(data_writedata),
    .data_readdata(data_readdata)
  );
  always #5 clk = ~clk;
  assign instr_readdata = instr_address[31:8] == 24'hBFC000 ? prog[instr_address[7:2]] : 32'h8C02_0004;
  assign data_readdata = dmem[data_address[7:2]];
  always @(posedge clk) if (data_write) dmem[data_address[7:2]] <= data_writedata;
  task automatic clear_prog;
    for (int i = 0; i < 64; i++) prog[i] = NOP;
  endtask
  task automatic do_reset;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    #1;
  endtask
  task automatic run_to_halt(input string name);
    int n = 0;
    while (active && n < 300) begin
      @(negedge clk);
      n++;
    end
    #1;
    total++;
    if (active !== 1'b0) $display("FAIL %s halt: active=%b after %0d cycles, required 0", name, active, n);
    else passed++;
  endtask
  task automatic test_reset;
    clear_prog();
    prog[0] = 32'hAC03_0004;
    @(negedge clk);
    #1;
    total++;
    if (data_write !== 1'b0 || data_read !== 1'b0) $display("FAIL reset_strobes: write=%b read=%b, required 0 0", data_write, data_read);
    else passed++;
    @(negedge clk);
    reset = 1'b1;
    #1;
    total++;
    if (active !== 1'b1) $display("FAIL reset_active: got %b, required 1", active);
    else passed++;
    total++;
    if (instr_address !== RV) $display("FAIL reset_pc: got %h, required %h", instr_address, RV);
    else passed++;
    total++;
    if (register_v0 !== 32'h0) $display("FAIL reset_v0: got %h, required 00000000", register_v0);
    else passed++;
  endtask
  task automatic test_halt;
    clear_prog();
    prog[0] = 32'h2402_0005;
    prog[1] = JR0;
    prog[2] = NOP;
    do_reset();
    run_to_halt("addiu_halt");
    total++;
    if (register_v0 !== 32'h5) $display("FAIL addiu_v0: got %h, required 00000005", register_v0);
    else passed++;
    repeat (4) @(negedge clk);
    #1;
    total++;
    if (instr_address !== 32'h0 || active !== 1'b0) $display("FAIL halt_freeze_pc: pc=%h active=%b, required 00000000 0", instr_address, active);
    else passed++;
    total++;
    if (register_v0 !== 32'h5 || data_read !== 1'b0) $display("FAIL halt_freeze_v0: v0=%h read=%b, required 00000005 0", register_v0, data_read);
    else passed++;
  endtask
  task automatic test_load_store;
    clear_prog();
    prog[0] = 32'h3C03_1234;
    prog[1] = 32'h3463_5678;
    prog[2] = 32'hAC03_0004;
    prog[3] = 32'h8C02_0004;
    prog[4] = JR0;
    prog[5] = NOP;
    do_reset();
    run_to_halt("load_store");
    total++;
    if (register_v0 !== 32'h1234_5678) $display("FAIL lw_v0: got %h, required 12345678", register_v0);
    else passed++;
    total++;
    if (dmem[1] !== 32'h1234_5678) $display("FAIL sw_mem: got %h, required 12345678", dmem[1]);
    else passed++;
  endtask
  task automatic test_branch;
    clear_prog();
    prog[0] = 32'h2402_0001;
    prog[1] = 32'h1000_0002;
    prog[2] = 32'h2442_0001;
    prog[3] = 32'h2442_0064;
    prog[4] = JR0;
    prog[5] = NOP;
    do_reset();
    run_to_halt("beq");
    total++;
    if (register_v0 !== 32'h2) $display("FAIL beq_delay_slot: got %h, required 00000002", register_v0);
    else passed++;
  endtask
  task automatic test_jal;
    clear_prog();
    prog[0] = 32'h0FF0_0004;
    prog[1] = NOP;
    prog[2] = 32'h2402_0007;
    prog[3] = 32'h2402_0009;
    prog[4] = 32'h03E0_1021;
    prog[5] = JR0;
    prog[6] = NOP;
    do_reset();
    run_to_halt("jal");
    total++;
    if (register_v0 !== 32'hBFC0_0008) $display("FAIL jal_link: got %h, required bfc00008", register_v0);
    else passed++;
  endtask
  task automatic test_alu;
    logic [31:0] second [5];
    logic [31:0] expect_v0 [5];
    second = '{32'h0002_1103, 32'h0002_1102, 32'h2C02_FFFF, 32'h0080_102A, 32'h0080_102B};
    expect_v0 = '{32'hFFFF_FFFF, 32'h0FFF_FFFF, 32'h0000_0001, 32'h0000_0001, 32'h0000_0000};
    for (int k = 0; k < 5; k++) begin
      clear_prog();
      prog[0] = 32'h2402_FFFF;
      prog[1] = 32'h2404_FFFD;
      prog[2] = second[k];
      prog[3] = JR0;
      prog[4] = NOP;
      do_reset();
      run_to_halt("alu");
      total++;
      if (register_v0 !== expect_v0[k]) $display("FAIL alu_case%0d: got %h, required %h", k, register_v0, expect_v0[k]);
      else passed++;
    end
  endtask
  task automatic load_count_prog;
    clear_prog();
    prog[0] = 32'h2402_0001;
    prog[1] = 32'h2442_0001;
    prog[2] = 32'hAC02_0008;
    prog[3] = 32'h2442_0001;
    prog[4] = JR0;
    prog[5] = NOP;
  endtask
  task automatic test_stall;
    load_count_prog();
    do_reset();
    repeat (2) @(negedge clk);
    clk_enable = 1'b0;
    #1;
    total++;
    if (data_write !== 1'b0) $display("FAIL stall_strobe: got %b, required 0", data_write);
    else passed++;
    repeat (5) @(negedge clk);
    #1;
    total++;
    if (instr_address !== RV + 32'd8) $display("FAIL stall_pc: got %h, required %h", instr_address, RV + 32'd8);
    else passed++;
    total++;
    if (register_v0 !== 32'h2 || dmem[2] !== 32'h0) $display("FAIL stall_state: v0=%h mem=%h, required 00000002 00000000", register_v0, dmem[2]);
    else passed++;
    clk_enable = 1'b1;
    #1;
    total++;
    if (data_write !== 1'b1) $display("FAIL resume_strobe: got %b, required 1", data_write);
    else passed++;
    run_to_halt("stall");
    total++;
    if (register_v0 !== 32'h3 || dmem[2] !== 32'h2) $display("FAIL stall_final: v0=%h mem=%h, required 00000003 00000002", register_v0, dmem[2]);
    else passed++;
  endtask
  task automatic test_mid_reset;
    load_count_prog();
    do_reset();
    repeat (2) @(negedge clk);
    do_reset();
    total++;
    if (instr_address !== RV || register_v0 !== 32'h0 || active !== 1'b1) $display("FAIL mid_reset: pc=%h v0=%h active=%b, required %h 00000000 1", instr_address, register_v0, active, RV);
    else passed++;
    run_to_halt("mid_reset");
    total++;
    if (register_v0 !== 32'h3) $display("FAIL mid_reset_final: got %h, required 00000003", register_v0);
    else passed++;
  endtask
  initial begin
    test_reset();
    test_halt();
    test_load_store();
    test_branch();
    test_jal();
    test_alu();
    test_stall();
    test_mid_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
